// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-sequencing controller:
// state encoding, opcodes, ALU selects and the per-state control decode.
package cpu_pkg;

    localparam int PC_W    = 7;
    localparam int IR_W    = 16;
    localparam int OP_W    = 4;
    localparam int DADDR_W = 8;
    localparam int RADDR_W = 4;
    localparam int ALU_W   = 3;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [OP_W-1:0] OP_NOOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_STORE = 4'h1;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD   = 4'h3;
    localparam logic [OP_W-1:0] OP_SUB   = 4'h4;
    localparam logic [OP_W-1:0] OP_HALT  = 4'h5;

    localparam logic [ALU_W-1:0] ALU_NONE = 3'd0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;

    typedef struct packed {
        logic [DADDR_W-1:0] d_addr;
        logic               d_wr;
        logic               rf_s;
        logic [RADDR_W-1:0] w_addr;
        logic               w_en;
        logic [RADDR_W-1:0] ra_addr;
        logic [RADDR_W-1:0] rb_addr;
        logic [ALU_W-1:0]   alu_s;
        logic               halted;
    } ctrl_t;

    // Unused opcodes fall through to NOOP.
    function automatic state_t opcode_state(input logic [OP_W-1:0] op);
        case (op)
            OP_STORE: return S_STORE;
            OP_LOAD:  return S_LOAD_A;
            OP_ADD:   return S_ADD;
            OP_SUB:   return S_SUB;
            OP_HALT:  return S_HALT;
            default:  return S_NOOP;
        endcase
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t st, input logic [IR_W-1:0] ir);
        ctrl_t c;
        c = '0;
        case (st)
            S_LOAD_A: begin
                c.d_addr = ir[11:4];
                c.w_addr = ir[3:0];
            end
            S_LOAD_B: begin
                c.d_addr = ir[11:4];
                c.w_addr = ir[3:0];
                c.rf_s   = 1'b1;
                c.w_en   = 1'b1;
            end
            S_STORE: begin
                c.d_addr  = ir[7:0];
                c.ra_addr = ir[11:8];
                c.d_wr    = 1'b1;
            end
            S_ADD, S_SUB: begin
                c.ra_addr = ir[11:8];
                c.rb_addr = ir[7:4];
                c.w_addr  = ir[3:0];
                c.w_en    = 1'b1;
                c.alu_s   = (st == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            S_HALT:  c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pc_counter.sv
// 7-bit program counter with clear and increment; wraps naturally at 127.
module pc_counter
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr) begin
            pc_d = '0;
        end else if (inc) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction controller: fetch, decode and per-opcode execute
// states, driving DataPath and register-file control from registered flops.
module control_fsm
    import cpu_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic [IR_W-1:0]     IM_data,
    output logic [PC_W-1:0]     IM_addr,
    output logic [DADDR_W-1:0]  D_Addr,
    output logic                D_wr,
    output logic                RF_s,
    output logic [RADDR_W-1:0]  RF_W_addr,
    output logic                RF_W_en,
    output logic [RADDR_W-1:0]  RF_Ra_addr,
    output logic [RADDR_W-1:0]  RF_Rb_addr,
    output logic [ALU_W-1:0]    Alu_s0,
    output logic [IR_W-1:0]     IR_out,
    output logic [3:0]          State_out,
    output logic                Halted
);

    state_t          state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic            pc_clr;
    logic            pc_inc;
    logic [PC_W-1:0] pc;

    assign pc_clr = (state_q == S_INIT);
    assign pc_inc = (state_q == S_FETCH);

    pc_counter u_pc (
        .clk (Clk),
        .rst (Reset),
        .clr (pc_clr),
        .inc (pc_inc),
        .pc  (pc)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_INIT: begin
                state_d = S_FETCH;
                ir_d    = '0;
            end
            S_FETCH: begin
                state_d = S_DECODE;
                ir_d    = IM_data;
            end
            S_DECODE: state_d = opcode_state(ir_q[15:12]);
            S_LOAD_A: state_d = S_LOAD_B;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        // Controls are precomputed for the upcoming state so they leave a flop.
        ctrl_d = decode_ctrl(state_d, ir_d);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_INIT;
            ir_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign IM_addr    = pc;
    assign D_Addr     = ctrl_q.d_addr;
    assign D_wr       = ctrl_q.d_wr;
    assign RF_s       = ctrl_q.rf_s;
    assign RF_W_addr  = ctrl_q.w_addr;
    assign RF_W_en    = ctrl_q.w_en;
    assign RF_Ra_addr = ctrl_q.ra_addr;
    assign RF_Rb_addr = ctrl_q.rb_addr;
    assign Alu_s0     = ctrl_q.alu_s;
    assign IR_out     = ir_q;
    assign State_out  = state_q;
    assign Halted     = ctrl_q.halted;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: a program-level trace model predicts every cycle's
// outputs from the ROM contents; literal checks pin key points of that model.
module tb_control_fsm;
    import cpu_pkg::*;

    logic        Clk;
    logic        Reset;
    logic [15:0] IM_data;
    logic [6:0]  IM_addr;
    logic [7:0]  D_Addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  Alu_s0;
    logic [15:0] IR_out;
    logic [3:0]  State_out;
    logic        Halted;

    control_fsm dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IM_data    (IM_data),
        .IM_addr    (IM_addr),
        .D_Addr     (D_Addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .Alu_s0     (Alu_s0),
        .IR_out     (IR_out),
        .State_out  (State_out),
        .Halted     (Halted)
    );

    // ---------------- clock / memory ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [15:0] rom [128];
    always @(posedge Clk) IM_data <= rom[IM_addr];

    // ---------------- model / scoreboard ----------------
    typedef struct packed {
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [3:0]  st;
        logic [7:0]  d_addr;
        logic        d_wr;
        logic        rf_s;
        logic [3:0]  w_addr;
        logic        w_en;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
        logic        halted;
    } obs_t;

    obs_t exp_q[$];
    int   vectors;
    int   miscompares;
    logic chk_en;
    int   cyc;

    function automatic obs_t blank(input state_t s, input logic [6:0] pc, input logic [15:0] ir);
        obs_t r;
        r        = '0;
        r.st     = s;
        r.pc     = pc;
        r.ir     = ir;
        r.halted = (s == S_HALT);
        return r;
    endfunction

    // Walk the program one instruction at a time, emitting one record per cycle.
    function automatic void build_trace(input int n);
        logic [6:0]  pc;
        logic [15:0] ir;
        obs_t        r;
        pc = '0;
        ir = '0;
        exp_q.delete();
        exp_q.push_back(blank(S_INIT, pc, ir));
        while (exp_q.size() < n) begin
            exp_q.push_back(blank(S_FETCH, pc, ir));
            ir = rom[pc];
            pc = pc + 7'd1;
            exp_q.push_back(blank(S_DECODE, pc, ir));
            case (ir[15:12])
                4'h1: begin
                    r = blank(S_STORE, pc, ir);
                    r.d_addr = ir[7:0];
                    r.ra     = ir[11:8];
                    r.d_wr   = 1'b1;
                    exp_q.push_back(r);
                end
                4'h2: begin
                    r = blank(S_LOAD_A, pc, ir);
                    r.d_addr = ir[11:4];
                    r.w_addr = ir[3:0];
                    exp_q.push_back(r);
                    r.st   = S_LOAD_B;
                    r.rf_s = 1'b1;
                    r.w_en = 1'b1;
                    exp_q.push_back(r);
                end
                4'h3, 4'h4: begin
                    r = blank((ir[15:12] == 4'h3) ? S_ADD : S_SUB, pc, ir);
                    r.ra   = ir[11:8];
                    r.rb   = ir[7:4];
                    r.w_addr = ir[3:0];
                    r.w_en = 1'b1;
                    r.alu  = (ir[15:12] == 4'h3) ? 3'd1 : 3'd2;
                    exp_q.push_back(r);
                end
                4'h5: begin
                    while (exp_q.size() < n) exp_q.push_back(blank(S_HALT, pc, ir));
                end
                default: exp_q.push_back(blank(S_NOOP, pc, ir));
            endcase
        end
        while (exp_q.size() > n) void'(exp_q.pop_back());
    endfunction

    // Single compare process: every enabled cycle pops one expected record.
    always @(negedge Clk) begin
        if (chk_en) begin
            obs_t got;
            obs_t exp;
            got = '{IM_addr, IR_out, State_out, D_Addr, D_wr, RF_s, RF_W_addr,
                    RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0, Halted};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL trace cyc%0d: no expected record, got %h", cyc, got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL trace cyc%0d: got st=%0d pc=%0d ir=%h vec=%h, expected st=%0d pc=%0d ir=%h vec=%h",
                             cyc, got.st, got.pc, got.ir, got, exp.st, exp.pc, exp.ir, exp);
                end
            end
            if (D_wr && RF_W_en) begin
                miscompares++;
                $display("FAIL excl cyc%0d: D_wr and RF_W_en both high", cyc);
            end
            cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    // Reset for one edge, then check n cycles starting with the INIT cycle.
    task automatic run(input int n);
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        build_trace(n);
        cyc    = 0;
        chk_en = 1'b1;
        repeat (n) @(negedge Clk);
        #1 chk_en = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        cyc         = 0;
        Reset       = 1'b1;
        clear_rom();
        repeat (2) @(negedge Clk);

        // Reset state.
        run(1);
        chk("reset_pc", 16'(IM_addr), 16'd0);
        chk("reset_ir", IR_out, 16'h0000);
        chk("reset_state", 16'(State_out), 16'(S_INIT));

        // NOOP stream: one fetch every 3 cycles.
        run(10);
        chk("noop_pc", 16'(IM_addr), 16'd3);

        // LOAD R3 <- D[0], full instruction plus next fetch.
        rom[0] = 16'h2003;
        run(9);
        chk("load_next_fetch", 16'(State_out), 16'(S_FETCH));
        chk("load_next_pc", 16'(IM_addr), 16'd2);

        // Stop in LOAD_B, then reset there.
        run(5);
        chk("loadb_daddr", 16'(D_Addr), 16'd0);
        chk("loadb_waddr", 16'(RF_W_addr), 16'd3);
        chk("loadb_rfs", 16'(RF_s), 16'd1);
        chk("loadb_wen_at_reset", 16'(RF_W_en), 16'd1);
        run(3);

        // STORE D[9] <- R2.
        clear_rom();
        rom[0] = 16'h1209;
        run(4);
        chk("store_dwr", 16'(D_wr), 16'd1);
        chk("store_daddr", 16'(D_Addr), 16'd9);
        chk("store_ra", 16'(RF_Ra_addr), 16'd2);
        chk("store_wen", 16'(RF_W_en), 16'd0);

        // ADD then SUB on the same registers.
        clear_rom();
        rom[0] = 16'h3124;
        rom[1] = 16'h4124;
        run(4);
        chk("add_abw", {4'h0, RF_Ra_addr, RF_Rb_addr, RF_W_addr}, 16'h0124);
        chk("add_alu", 16'(Alu_s0), 16'd1);
        run(7);
        chk("sub_abw", {4'h0, RF_Ra_addr, RF_Rb_addr, RF_W_addr}, 16'h0124);
        chk("sub_alu", 16'(Alu_s0), 16'd2);

        // HALT at address 1, hold 20+ cycles, then reset out of it.
        clear_rom();
        rom[1] = 16'h5000;
        run(30);
        chk("halt_flag", 16'(Halted), 16'd1);
        chk("halt_pc", 16'(IM_addr), 16'd2);
        chk("halt_ir", IR_out, 16'h5000);
        run(2);
        chk("restart_state", 16'(State_out), 16'(S_FETCH));
        chk("restart_pc", 16'(IM_addr), 16'd0);
        chk("restart_halted", 16'(Halted), 16'd0);

        // PC wrap: 128 NOOPs brings the counter back to 0.
        clear_rom();
        run(384);
        chk("wrap_pc", 16'(IM_addr), 16'd0);
        chk("wrap_state", 16'(State_out), 16'(S_DECODE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
